reaction_round_ctrl: RTL

Round sequencer for the LED reaction game on the MAX10 board. It generates the level-dependent sweep tick and drives the ten-LED chaser. It debounces the player's press and judges each press as a hit or a miss. It advances through three speed levels to a WIN or LOSE terminal state. The block sits between the raw KEY[1] pin and the LEDR bus. Its `game_state`/`level` outputs feed the separate HEX message decoder.

---
 rtl/reaction_pkg.sv | 24 ++
 rtl/key_debounce.sv | 58 +++++
 rtl/reaction_round_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the LED reaction game round sequencer.
package reaction_pkg;

  typedef enum logic [1:0] {
    GS_READY = 2'd0,
    GS_RUN   = 2'd1,
    GS_WIN   = 2'd2,
    GS_LOSE  = 2'd3
  } game_state_t;

  localparam int LED_COUNT  = 10;
  localparam int NUM_LEVELS = 3;

  // Larger of two unsigned values, used to size the shared tick counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on the debounced press (1->0) edge. Button is active-low.
module key_debounce
  import reaction_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = cnt_width(DEBOUNCE);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Next-state: the debounced level follows the synchronized key only after
  // it has disagreed for DEBOUNCE consecutive cycles; any agreement restarts.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = deb_q & ~deb_d;
  end

  // State registers; reset leaves the key in the released state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the LED reaction game: level-dependent sweep tick,
// ten-LED chaser, press judgement and READY/RUN/WIN/LOSE progression.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_L1      = 50_000_000,
  parameter int unsigned TICK_L2      = 25_000_000,
  parameter int unsigned TICK_L3      = 12_500_000,
  parameter int unsigned READY_TICK   = 25_000_000,
  parameter int unsigned READY_BLINKS = 8,
  parameter int unsigned TARGET       = 5,
  parameter int unsigned DEBOUNCE     = 500_000
) (
  input  logic                 MAX10_CLK1_50,
  input  logic                 reset_n,
  input  logic                 press_n,
  output logic [LED_COUNT-1:0] led,
  output game_state_t          game_state,
  output logic [1:0]           level,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam int unsigned MAX_P =
    max_u(max_u(TICK_L1, TICK_L2), max_u(TICK_L3, READY_TICK));
  localparam int CW = cnt_width(MAX_P);
  localparam int BW = cnt_width(READY_BLINKS + 1);
  localparam logic [3:0] LAST_POS = 4'(LED_COUNT - 1);

  game_state_t          state_q, state_d;
  logic [1:0]           level_q, level_d;
  logic [LED_COUNT-1:0] led_q, led_d;
  logic [3:0]           pos_q, pos_d;
  logic [BW-1:0]        blink_q, blink_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic [CW-1:0]        period_m1;
  logic                 tick;
  logic                 press_evt;
  logic [3:0]           step_pos;
  logic [LED_COUNT-1:0] step_led;

  key_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_key_debounce (
    .clk        (MAX10_CLK1_50),
    .rst_n      (reset_n),
    .key_n      (press_n),
    .press_pulse(press_evt)
  );

  // Terminal count of the tick counter for the current state and level.
  always_comb begin
    period_m1 = CW'(READY_TICK - 1);
    if (state_q == GS_RUN) begin
      case (level_q)
        2'd1:    period_m1 = CW'(TICK_L1 - 1);
        2'd2:    period_m1 = CW'(TICK_L2 - 1);
        default: period_m1 = CW'(TICK_L3 - 1);
      endcase
    end
  end

  assign tick     = (cnt_q == period_m1);
  assign step_pos = (pos_q == 4'd0) ? LAST_POS : pos_q - 4'd1;

  // One-hot image of the position the sweep moves to on the next tick.
  for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_step_led
    assign step_led[gi] = (step_pos == 4'(gi));
  end

  // FSM next-state and datapath; a judged press wins over a same-cycle tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    led_d   = led_q;
    pos_d   = pos_q;
    blink_d = blink_q;
    cnt_d   = cnt_q + 1'b1;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      GS_READY: begin
        if (tick) begin
          cnt_d = '0;
          if (blink_q == BW'(READY_BLINKS)) begin
            state_d = GS_RUN;
            led_d   = '0;
            led_d[LAST_POS] = 1'b1;
            pos_d   = LAST_POS;
            blink_d = '0;
          end else begin
            led_d[TARGET] = ~led_q[TARGET];
            blink_d       = blink_q + 1'b1;
          end
        end
      end
      GS_RUN: begin
        if (press_evt) begin
          cnt_d = '0;
          if (pos_q == 4'(TARGET)) begin
            hit_d = 1'b1;
            if (level_q == 2'(NUM_LEVELS)) begin
              state_d = GS_WIN;
              led_d   = '1;
            end else begin
              state_d = GS_READY;
              level_d = level_q + 2'd1;
              led_d   = '0;
            end
          end else begin
            miss_d  = 1'b1;
            state_d = GS_LOSE;
            led_d   = '0;
          end
        end else if (tick) begin
          cnt_d = '0;
          pos_d = step_pos;
          led_d = step_led;
        end
      end
      GS_WIN: begin
        cnt_d = '0;
        led_d = '1;
      end
      GS_LOSE: begin
        cnt_d = '0;
        led_d = '0;
      end
    endcase
  end

  // State register; reset returns to READY at level 1 with the sweep parked at 9.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GS_READY;
      level_q <= 2'd1;
      led_q   <= '0;
      pos_q   <= LAST_POS;
      blink_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= led_d;
      pos_q   <= pos_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign led        = led_q;
  assign game_state = state_q;
  assign level      = level_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule
